// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes instruction memory and gates core reset
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t              state, state_nxt;
  logic [15:0]         count;
  logic [23:0]         word_sr;
  logic [1:0]          byte_idx;
  logic [7:0]          csum;
  logic                accept;
  logic                start_ok;
  logic                len_bad;
  logic                last_word;
  logic [15:0]         len_full;
  logic [ADDR_WIDTH:0] wl_next;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign len_full  = {count[15:8], in_data};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
  assign wl_next   = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_word = (byte_idx == 2'd3) && ({1'b0, count} == 17'(wl_next));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
      LEN_HI:          if (accept) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = len_bad ? ERR : DATA;
      DATA:            if (accept && last_word) state_nxt = CHECK;
      CHECK:           if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // Status is a pure decode of state; the core stays in reset unless the last load succeeded.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_rst  = 1'b1;
    case (state)
      LEN_HI, LEN_LO, DATA, CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    begin done = 1'b1; cpu_rst = 1'b0; end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      word_sr      <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        count        <= '0;
        byte_idx     <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (accept) begin
        case (state)
          LEN_HI: count[15:8] <= in_data;
          LEN_LO: count[7:0]  <= in_data;
          DATA: begin
            word_sr  <= {word_sr[15:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes a word: write it next cycle at the running word count.
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {word_sr, in_data};
              imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
              words_loaded <= wl_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int AW = 10;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int   total = 0;
  int   bad = 0;
  int   we_count = 0;
  logic we_prev = 1'b0;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_count++;
      chk("we_not_back_to_back", 32'(we_prev), 32'd0);
    end
    we_prev = imem_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $error("FAIL accept_timeout: got in_ready=%0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic byte_q_t rand_frame(input int cnt, input bit good);
    byte_q_t     q;
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    q.push_back(8'(cnt >> 8));
    q.push_back(8'(cnt));
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) begin
        q.push_back(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
    q.push_back(good ? cs : (cs ^ 8'(1 + $urandom_range(0, 254))));
    return q;
  endfunction

  // Reference: count from the header, words big-endian, checksum is XOR of payload bytes.
  task automatic load(input byte_q_t fr, input bit gaps, input int mid_start, input string tag);
    int          cnt;
    int          we0;
    int          idx;
    bit          ok;
    logic [7:0]  cs;
    logic [31:0] w;
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ":cpu_rst_after_start"}, 32'(cpu_rst), 32'd1);
    chk({tag, ":busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, ":done_cleared"}, 32'(done), 32'd0);
    chk({tag, ":err_cleared"}, 32'(err), 32'd0);
    chk({tag, ":words_cleared"}, 32'(words_loaded), 32'd0);
    we0 = we_count;
    cnt = int'({fr[0], fr[1]});
    send_byte(fr[0], gaps);
    send_byte(fr[1], gaps);
    if (cnt == 0 || cnt > (1 << AW)) begin
      chk({tag, ":len_err"}, 32'(err), 32'd1);
      chk({tag, ":len_busy"}, 32'(busy), 32'd0);
      chk({tag, ":len_cpu_rst"}, 32'(cpu_rst), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ":len_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ":len_no_we"}, 32'(we_count - we0), 32'd0);
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      idx = 2 + 4 * i;
      w = {fr[idx], fr[idx+1], fr[idx+2], fr[idx+3]};
      for (int k = 0; k < 4; k++) begin
        if (idx + k == mid_start) begin
          in_valid = 1'b0;
          start    = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          chk({tag, ":mid_start_busy"}, 32'(busy), 32'd1);
          chk({tag, ":mid_start_words"}, 32'(words_loaded), 32'(i));
        end
        send_byte(fr[idx+k], gaps);
        cs ^= fr[idx+k];
      end
      chk({tag, ":we"}, 32'(imem_we), 32'd1);
      chk({tag, ":addr"}, 32'(imem_addr), 32'(i));
      chk({tag, ":wdata"}, imem_wdata, w);
    end
    ok = (fr[2 + 4*cnt] == cs);
    send_byte(fr[2 + 4*cnt], gaps);
    chk({tag, ":done"}, 32'(done), 32'(ok));
    chk({tag, ":err"}, 32'(err), 32'(!ok));
    chk({tag, ":cpu_rst"}, 32'(cpu_rst), 32'(!ok));
    chk({tag, ":busy_end"}, 32'(busy), 32'd0);
    chk({tag, ":ready_end"}, 32'(in_ready), 32'd0);
    chk({tag, ":words_loaded"}, 32'(words_loaded), 32'(cnt));
    @(posedge clk); #1;
    chk({tag, ":we_pulses"}, 32'(we_count - we0), 32'(cnt));
  endtask

  initial begin
    byte_q_t nom_good, nom_bad, len_zero, len_big, dead, big;
    nom_good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    nom_bad  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h88};
    len_zero = '{8'h00, 8'h00};
    len_big  = '{8'h04, 8'h01};
    dead     = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:in_ready", 32'(in_ready), 32'd0);
    chk("rst:imem_we", 32'(imem_we), 32'd0);
    chk("rst:imem_addr", 32'(imem_addr), 32'd0);
    chk("rst:imem_wdata", imem_wdata, 32'd0);
    chk("rst:cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:words", 32'(words_loaded), 32'd0);
    rst = 1'b0;

    load(nom_good, 1'b0, -1, "nominal");
    load(nom_bad, 1'b0, -1, "bad_csum");
    load(len_zero, 1'b0, -1, "len_zero");
    load(len_big, 1'b0, -1, "len_big");

    in_valid = 1'b1;
    repeat (5) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("idle_valid:ready", 32'(in_ready), 32'd0);
    chk("idle_valid:err_held", 32'(err), 32'd1);
    load(nom_good, 1'b1, -1, "gaps");

    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(nom_good[i], 1'b0);
    chk("midrst:words_before", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst:cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst:words", 32'(words_loaded), 32'd0);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:ready", 32'(in_ready), 32'd0);
    load(nom_good, 1'b0, -1, "after_rst");

    load(dead, 1'b0, 4, "reload");

    for (int r = 0; r < 6; r++) begin
      load(rand_frame($urandom_range(1, 8), 1'($urandom_range(0, 1))),
           1'($urandom_range(0, 1)), -1, "random");
    end

    big = rand_frame(1 << AW, 1'b1);
    load(big, 1'b0, -1, "capacity");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
